// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: the buffered entry, the
// instruction memory request/response pair and the bundled stage I/O.
package fetch_pkg;

    localparam int XLEN = 32;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_type;

    // Instruction memory request: a single word fetch.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } imem_req_type;

    // Instruction memory response: ready is a one-cycle completion pulse.
    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] rdata;
    } imem_rsp_type;

    // Everything the fetch stage samples.
    typedef struct packed {
        imem_rsp_type    imem;
        logic            redir_valid;
        logic [XLEN-1:0] redir_addr;
        logic            inst_ready;
    } fetch_in_type;

    // Everything the fetch stage drives.
    typedef struct packed {
        imem_req_type    imem;
        logic            inst_valid;
        fetch_entry_type inst;
    } fetch_out_type;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small first-word-fall-through FIFO of fetch entries. The head is held in
// its own register so the decode-facing outputs never come straight out of
// the storage array. Flush has priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_type          wr_data,
    output fetch_entry_type          head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_type mem_reg [DEPTH];
    fetch_entry_type head_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   rd_ptr_inc;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;
    logic            is_empty;

    assign is_empty   = (count_reg == '0);
    assign do_push    = push && !flush;
    // Popping an empty FIFO is a harmless no-op.
    assign do_pop     = pop && !flush && !is_empty;
    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    // Storage array; no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // Registered head: takes the incoming entry when it becomes the oldest,
    // otherwise the next stored entry after a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg <= '0;
        end else if (!flush) begin
            if (do_push && (is_empty || (do_pop && count_reg == CW'(1)))) begin
                head_reg <= wr_data;
            end else if (do_pop) begin
                head_reg <= mem_reg[rd_ptr_inc];
            end
        end
    end

    // A push into a full FIFO means the upstream issue throttle is broken.
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(push && count_reg == CW'(DEPTH)));
        end
    end

    assign head  = head_reg;
    assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch stage. Keeps the PC, issues one word fetch at a time to
// instruction memory, and queues returned instructions for decode. A redirect
// from execute flushes the queue and marks any in-flight fetch as stale.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_valid,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_in_type    d;
    fetch_out_type   q;

    logic [31:0]     pc_reg;
    logic [31:0]     pc_next;
    logic [31:0]     addr_reg;
    logic [31:0]     addr_next;
    logic            pending_reg;
    logic            pending_next;
    logic            discard_reg;
    logic            discard_next;
    logic [31:0]     redir_target;
    logic            complete;
    logic            push;
    logic            pop;
    logic            issue;
    logic [CW-1:0]   count;
    fetch_entry_type head;
    fetch_entry_type push_entry;

    assign d.imem.ready  = imem_ready;
    assign d.imem.rdata  = imem_rdata;
    assign d.redir_valid = redir_valid;
    assign d.redir_addr  = redir_addr;
    assign d.inst_ready  = inst_ready;

    assign redir_target = word_align(d.redir_addr);
    assign complete     = pending_reg && d.imem.ready;
    // Data is kept only if it belongs to the current path: not stale from an
    // earlier redirect and not overtaken by a redirect in this very cycle.
    assign push         = complete && !discard_reg && !d.redir_valid;
    assign pop          = q.inst_valid && d.inst_ready;
    // A redirect empties the queue, so it also frees room for a new fetch.
    // Counting the pending request keeps a landing slot reserved for it.
    assign issue        = !pending_reg && (d.redir_valid || count < CW'(DEPTH));
    assign push_entry   = '{pc: addr_reg, inst: d.imem.rdata};

    // Next-state for the PC, the outstanding request and the stale marker.
    always_comb begin
        pc_next      = pc_reg;
        addr_next    = addr_reg;
        pending_next = pending_reg;
        discard_next = discard_reg;

        if (d.redir_valid) begin
            pc_next = redir_target;
        end else if (push) begin
            pc_next = addr_reg + 32'd4;
        end

        if (d.redir_valid && pending_reg && !d.imem.ready) begin
            discard_next = 1'b1;
        end else if (complete) begin
            discard_next = 1'b0;
        end

        // A request is never retracted: address only changes on a new issue.
        if (issue) begin
            pending_next = 1'b1;
            addr_next    = d.redir_valid ? redir_target : pc_reg;
        end else if (complete) begin
            pending_next = 1'b0;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg      <= PC_RESET;
            addr_reg    <= PC_RESET;
            pending_reg <= 1'b0;
            discard_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            addr_reg    <= addr_next;
            pending_reg <= pending_next;
            discard_reg <= discard_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (d.redir_valid),
        .wr_data (push_entry),
        .head    (head),
        .count   (count)
    );

    // The request valid is exactly the registered pending flag.
    assign q.imem.valid = pending_reg;
    assign q.imem.addr  = addr_reg;
    assign q.inst_valid = (count != '0);
    assign q.inst       = head;

    assign imem_valid = q.imem.valid;
    assign imem_addr  = q.imem.addr;
    assign inst_valid = q.inst_valid;
    assign inst_pc    = q.inst.pc;
    assign inst_data  = q.inst.inst;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction fetch stage; sits directly downstream of the branch compare unit's result path.
- Execute combines the compare unit's `branch` output with jal/jalr decode into a redirect request. That request drives this block.
- Generates the PC and issues word fetches on the instruction memory port, one request outstanding at a time.
- Buffers returned instructions with their PCs in a small FIFO toward decode. On redirect it flushes the FIFO and discards stale in-flight data.

Parameters:
- PC_RESET, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- imem_valid  out  1  fetch request valid.
- imem_ready  in  1  one-cycle pulse; request completed, imem_rdata valid this cycle.
- imem_addr  out  32  fetch address, word aligned.
- imem_rdata  in  32  fetched instruction.
- redir_valid  in  1  taken branch or jump from execute, one-cycle pulse.
- redir_addr  in  32  redirect target; bits [1:0] ignored (alignment trap raised upstream).
- inst_valid  out  1  FIFO head valid toward decode.
- inst_ready  in  1  decode accepts head.
- inst_pc  out  32  PC of head entry.
- inst_data  out  32  instruction of head entry.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=PC_RESET; FIFO empty (count=0); pending=0; discard=0.
  - imem_valid=0, imem_addr=PC_RESET, inst_valid=0, inst_pc=0, inst_data=0.
- Issue:
  - imem_valid is registered. It rises the cycle after pending=0 and count+pending<DEPTH, with imem_addr=pc. Set pending=1.
  - First request appears in the first clock edge after rst deasserts.
  - imem_valid and imem_addr stay stable until imem_ready, including across redirects (no request retraction).
- Completion (imem_ready=1):
  - pending clears and imem_valid drops for at least one cycle.
  - If discard=0 and redir_valid=0: push {imem_addr, imem_rdata}; pc<=imem_addr+4, wrapping modulo 2^32.
  - If discard=1: drop data, clear discard; pc already holds the redirect target.
- Redirect (redir_valid=1):
  - FIFO flushed (count=0) at this edge; a pop in the same cycle is ignored.
  - pc<=redir_addr & ~3.
  - If a request is pending and imem_ready=0: discard<=1.
  - If imem_ready=1 in the same cycle: data dropped, discard stays 0.
  - Several redirects while pending: last target wins; discard stays 1.
- Output:
  - inst_valid = (count!=0); inst_pc/inst_data come from the registered head.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle: count unchanged.
- Latency:
  - imem_ready at cycle N gives inst_valid at N+1.
  - Redirect at N gives imem_valid with the target at N+1 if no request is pending.
- Boundaries:
  - The issue rule guarantees no overflow; a push when full is impossible and is an assertion failure.
  - Empty FIFO with inst_ready=1 is a no-op.
  - Read and write pointers wrap modulo DEPTH.
  - Reset mid-request drops pending state; the memory side must also be reset.

Decomposition:
- Package wires: fetch_in_type, fetch_out_type, fetch_entry_type {pc, inst}, and imem request/response structs, consistent with bcu_in_type/bcu_out_type.
- Sub-module fetch_fifo:
  - Parameter DEPTH, payload fetch_entry_type.
  - Controls: push, pop, flush.
  - Outputs: head, count.
  - Flush has priority over push and pop.
- fetch_ctrl holds the pc, pending and discard registers and the issue logic.

Test Plan:
- Reset, memory ready one cycle after each request with rdata=addr^32'hA5A5_A5A5, inst_ready=1:
  - imem_addr sequence is 0,4,8,C.
  - inst_pc/inst_data pairs match, each one cycle after its imem_ready.
- inst_ready=0, memory always responsive:
  - Exactly DEPTH=4 requests issued (addr 0..C), then imem_valid stays 0.
  - Raising inst_ready drains 4 entries in order, then fetching resumes at 0x10.
- redir_valid with redir_addr=0x100 while a request to 0x8 is pending, imem_ready delayed 3 cycles:
  - 0x8 data is never output.
  - The next imem_addr is 0x100; the FIFO is empty right after the redirect.
- redir_valid in the same cycle as imem_ready for 0x4 with target 0x203:
  - 0x4 is dropped; the next request is 0x200.
- Two redirects (0x40 then 0x80) during one pending request:
  - Only 0x80 is fetched afterwards.
- Assert rst mid-request with 3 FIFO entries:
  - All outputs are at reset values immediately, without waiting for a clock edge.
  - After release, the first request is PC_RESET.
